// File: rtl/rgb_hue_sequencer.sv
// Steps hue around a full-saturation HSV wheel and emits RGB PWM duties; new duties load
// one cycle after a period_start while a step is pending, with no backpressure on the upstream.
module rgb_hue_sequencer #(
  parameter  int PWM_INTERVAL     = 1200,
  parameter  int STEPS_PER_SECTOR = 200,
  parameter  int TICKS_PER_STEP   = 10000,
  localparam int DUTY_W           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              duty_valid,
  output logic [2:0]        sector
);

  localparam int DUTY_STEP = PWM_INTERVAL / STEPS_PER_SECTOR;
  localparam int TICK_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int STEP_W    = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_SECTOR - 1);
  localparam logic [DUTY_W-1:0] FULL      = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] DSTEP     = DUTY_W'(DUTY_STEP);

  logic [TICK_W-1:0] tick;
  logic [STEP_W-1:0] step;
  logic [2:0]        sector_q;
  logic              pending;
  logic              step_adv;
  logic              load;
  logic [DUTY_W-1:0] ramp;
  logic [DUTY_W-1:0] up;
  logic [DUTY_W-1:0] dn;
  logic [DUTY_W-1:0] stg_r;
  logic [DUTY_W-1:0] stg_g;
  logic [DUTY_W-1:0] stg_b;

  assign step_adv = enable && (tick == TICK_LAST);
  assign load     = period_start && pending;
  assign sector   = sector_q;

  // step < STEPS_PER_SECTOR keeps ramp at or below PWM_INTERVAL - DUTY_STEP, so no overflow
  assign ramp = DUTY_W'(step) * DSTEP;
  assign up   = ramp;
  assign dn   = FULL - ramp;

  always_comb begin
    stg_r = FULL;
    stg_g = '0;
    stg_b = '0;
    case (sector_q)
      3'd0: begin stg_r = FULL; stg_g = up;   stg_b = '0;   end
      3'd1: begin stg_r = dn;   stg_g = FULL; stg_b = '0;   end
      3'd2: begin stg_r = '0;   stg_g = FULL; stg_b = up;   end
      3'd3: begin stg_r = '0;   stg_g = dn;   stg_b = FULL; end
      3'd4: begin stg_r = up;   stg_g = '0;   stg_b = FULL; end
      3'd5: begin stg_r = FULL; stg_g = '0;   stg_b = dn;   end
      default: begin stg_r = FULL; stg_g = '0; stg_b = '0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= '0;
      step     <= '0;
      sector_q <= 3'd0;
    end else begin
      if (enable) begin
        tick <= step_adv ? '0 : tick + 1'b1;
      end
      if (step_adv) begin
        step <= (step == STEP_LAST) ? '0 : step + 1'b1;
        // Illegal sector codes recover to 0 on the next step regardless of step position
        if (sector_q > 3'd5) begin
          sector_q <= 3'd0;
        end else if (step == STEP_LAST) begin
          sector_q <= (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        end
      end
    end
  end

  // A step landing on the load cycle keeps pending set so the newer values follow next period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      duty_r     <= FULL;
      duty_g     <= '0;
      duty_b     <= '0;
      duty_valid <= 1'b0;
    end else begin
      if (step_adv) begin
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
      if (load) begin
        duty_r <= stg_r;
        duty_g <= stg_g;
        duty_b <= stg_b;
      end
      duty_valid <= load;
    end
  end

endmodule
